pipelined_subtractor: RTL and testbench

PIPELINED_SUBTRACTOR -- requirements
Module: pipelined_subtractor

---
 rtl/pipelined_subtractor.sv | 114 +++++++++++
 tb/tb_pipelined_subtractor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_subtractor.sv
// Pipelined a - b - bin built from one 4-bit carry-lookahead slice per stage.
// A single global advance signal stalls the whole pipe when the output is blocked.
module pipelined_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / 4;

    logic             advance;

    logic             v_q   [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] r_q   [STAGES];
    logic             ovf_q;

    // Inputs seen by each stage's slice; element 0 comes from the ports.
    logic [WIDTH-1:0] op_a  [STAGES];
    logic [WIDTH-1:0] op_nb [STAGES];
    logic             cin   [STAGES];
    logic             vin   [STAGES];
    logic [WIDTH-1:0] rin   [STAGES];

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    assign op_a[0]  = a;
    assign op_nb[0] = ~b;
    assign cin[0]   = ~bin;
    assign vin[0]   = in_valid;
    assign rin[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] s;
        logic [4:0] c;

        assign p = op_a[k][3:0] ^ op_nb[k][3:0];
        assign g = op_a[k][3:0] & op_nb[k][3:0];

        assign c[0] = cin[k];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);

        assign s = p ^ c[3:0];

        // Carry resets to 1 so that the exposed borrow (its inverse) reads 0.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b1;
                r_q[k] <= '0;
            end else if (advance) begin
                v_q[k] <= vin[k];
                c_q[k] <= c[4];
                r_q[k] <= rin[k] | (WIDTH'(s) << (4 * k));
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] nb_q;

            // Operands shift down a nibble so the next slice always reads bits [3:0].
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    nb_q <= '0;
                end else if (advance) begin
                    a_q  <= op_a[k] >> 4;
                    nb_q <= op_nb[k] >> 4;
                end
            end

            assign op_a[k+1]  = a_q;
            assign op_nb[k+1] = nb_q;
            assign cin[k+1]   = c_q[k];
            assign vin[k+1]   = v_q[k];
            assign rin[k+1]   = r_q[k];
        end else begin : g_last
            // Signed overflow is the carry into the MSB differing from the carry out.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= c[3] ^ c[4];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign diff      = r_q[STAGES-1];
    assign bout      = ~c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Scoreboard bench for pipelined_subtractor at WIDTH=16 with directed vectors.
module tb_pipelined_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          acc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    pipelined_subtractor #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input vec_t v, input bit lat);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        bin      = v.bin;
        n        = 0;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout in_ready stuck actual=0 required=1");
                return;
            end
        end
        e.d   = v.d;
        e.bo  = v.bo;
        e.ov  = v.ov;
        e.acc = cyc;
        e.lat = lat;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    // Monitor: pops expected results on every output transfer and checks holds.
    initial begin : monitor
        exp_t        e;
        bit          held = 1'b0;
        logic [15:0] hd;
        logic        hb;
        logic        ho;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", diff);
                end else begin
                    e = q.pop_front();
                    chk("diff", diff, e.d);
                    chk("bout", bout, e.bo);
                    chk("ovf", ovf, e.ov);
                    if (e.lat) chk("latency", cyc - e.acc, 4);
                end
                held = 1'b0;
            end else if (!rst && out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (held) begin
                    chk("stall_diff", diff, hd);
                    chk("stall_bout", bout, hb);
                    chk("stall_ovf", ovf, ho);
                end
                held = 1'b1;
                hd   = diff;
                hb   = bout;
                ho   = ovf;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish actual=running required=done");
        $fatal(1, "watchdog");
    end

    vec_t dir[4];
    vec_t strm[8];
    vec_t rstv[3];
    vec_t dropped;
    vec_t resume_v;

    initial begin : main
        dir[0] = '{16'h0005, 16'h0004, 1'b0, 16'h0001, 1'b0, 1'b0};
        dir[1] = '{16'h0001, 16'h0004, 1'b0, 16'hFFFD, 1'b1, 1'b0};
        dir[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        dir[3] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        strm[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        strm[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        strm[2] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        strm[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        strm[4] = '{16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0};
        strm[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0};
        strm[6] = '{16'h00FF, 16'h0F00, 1'b1, 16'hF1FE, 1'b1, 1'b0};
        strm[7] = '{16'h7000, 16'h9000, 1'b0, 16'hE000, 1'b1, 1'b1};

        rstv[0]  = '{16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0};
        rstv[1]  = '{16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0};
        rstv[2]  = '{16'h3333, 16'h0003, 1'b0, 16'h3330, 1'b0, 1'b0};
        dropped  = '{16'h4444, 16'h0004, 1'b0, 16'h4440, 1'b0, 1'b0};
        resume_v = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_diff", diff, 0);
        chk("reset_bout", bout, 0);
        chk("reset_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single isolated operations, latency checked.
        foreach (dir[i]) begin
            send(dir[i], 1'b1);
            idle();
            drain();
        end

        // Back-to-back stream with a three-cycle output stall mid-stream.
        fork
            begin
                foreach (strm[i]) send(strm[i], 1'b0);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Three in flight, then a reset edge that also carries a new operand.
        foreach (rstv[i]) send(rstv[i], 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = dropped.a;
        b        = dropped.b;
        bin      = dropped.bin;
        q.delete();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("rst_no_output", out_valid, 0);
        end

        send(resume_v, 1'b1);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
